// File: rtl/clock_divider_unit.sv
// clock_divider_unit: two glitch-free programmable clock dividers (ratio 1..7)
// deriving core_clk and user_clk from a single source clock.
// Optional feature macro: CLK_EDGE_COUNT_EN adds rise-edge counters for both
// outputs with a start/stop measurement window.
module clock_divider_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       core_div,
    input  logic [2:0]       user_div,
    output logic             core_clk,
    output logic             user_clk
`ifdef CLK_EDGE_COUNT_EN
    ,
    input  logic             count_start,
    input  logic             count_stop,
    output logic [CNT_W-1:0] core_count,
    output logic [CNT_W-1:0] user_count,
    output logic             count_busy
`endif
);

    logic [2:0] div_in [2];
    logic [1:0] clk_out;

    assign div_in[0] = core_div;
    assign div_in[1] = user_div;
    assign core_clk  = clk_out[0];
    assign user_clk  = clk_out[1];

`ifdef CLK_EDGE_COUNT_EN
    logic [1:0] rise_ev;
`endif

    // Channel 0 is core, channel 1 is user; both are identical.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic [2:0] cnt_q;
        logic [2:0] cnt_d;
        logic [2:0] n_act_q;
        logic [2:0] n_act_d;
        logic [2:0] n_eff;
        logic       init_q;
        logic       pos_q;
        logic       pos_d;
        logic       neg_q;
        logic       neg_d;
        logic       en_q;
        logic       en_d;
        logic       bypass;
        logic       wrap;

        // Period counter, divisor sampling at wrap and output decode.
        // Until the first edge after reset, the live divisor input is used
        // so the ratio present at reset release takes effect immediately.
        always_comb begin
            n_eff   = init_q ? div_in[gi] : n_act_q;
            bypass  = (n_eff <= 3'd1);
            wrap    = bypass || (cnt_q == (n_eff - 3'd1));
            cnt_d   = wrap ? 3'd0 : (cnt_q + 3'd1);
            n_act_d = wrap ? div_in[gi] : n_eff;
            pos_d   = !bypass && (cnt_q < (n_eff >> 1));
            // Only odd ratios stretch the high phase by half a cycle
            neg_d   = pos_q & n_act_q[0];
            // Bypass enable changes only while clock is low: no runt pulse
            en_d    = bypass;
        end

        // Posedge state: counter, active divisor, output flop
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cnt_q   <= 3'd0;
                n_act_q <= 3'd0;
                init_q  <= 1'b1;
                pos_q   <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                n_act_q <= n_act_d;
                init_q  <= 1'b0;
                pos_q   <= pos_d;
            end
        end

        // Negedge helpers: half-cycle stretch and bypass gate enable
        always_ff @(negedge clock or posedge reset) begin
            if (reset) begin
                neg_q <= 1'b0;
                en_q  <= 1'b0;
            end else begin
                neg_q <= neg_d;
                en_q  <= en_d;
            end
        end

        assign clk_out[gi] = (clock & en_q) | pos_q | neg_q;

`ifdef CLK_EDGE_COUNT_EN
        // The output rises on the edge after each wrap; every cycle in bypass
        assign rise_ev[gi] = bypass || (cnt_q == 3'd0);
`endif
    end

`ifdef CLK_EDGE_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             busy_q;
    logic             busy_d;
    logic [1:0]       rise_q;
    logic [CNT_W-1:0] edge_cnt_q [2];
    logic [CNT_W-1:0] edge_cnt_d [2];

    // Window control (start wins over stop) and saturating count update
    always_comb begin
        busy_d = busy_q;
        if (count_start) begin
            busy_d = 1'b1;
        end else if (count_stop) begin
            busy_d = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            edge_cnt_d[i] = edge_cnt_q[i];
            if (count_start) begin
                edge_cnt_d[i] = '0;
            end else if (busy_q && rise_q[i] && (edge_cnt_q[i] != {CNT_W{1'b1}})) begin
                edge_cnt_d[i] = edge_cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Registered rise events, window flag and counts
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            rise_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                edge_cnt_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            rise_q <= rise_ev;
            for (int i = 0; i < 2; i++) begin
                edge_cnt_q[i] <= edge_cnt_d[i];
            end
        end
    end

    assign core_count = edge_cnt_q[0];
    assign user_count = edge_cnt_q[1];
    assign count_busy = busy_q;
`endif

endmodule

// File: tb/tb_clock_divider_unit.sv
// Testbench for clock_divider_unit: table of divisor settings measured on
// both clock phases, plus reset, divisor-change and edge-counter sequences.
module tb_clock_divider_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  core_div = 3'd1;
    logic [2:0]  user_div = 3'd1;
    logic        core_clk;
    logic        user_clk;
`ifdef CLK_EDGE_COUNT_EN
    logic        count_start = 1'b0;
    logic        count_stop = 1'b0;
    logic [15:0] core_count;
    logic [15:0] user_count;
    logic        count_busy;
`endif

    int tests = 0;
    int fails = 0;

    logic [63:0] cs;
    logic [63:0] us;
    int          p;
    int          h;
    logic        found;
    logic        prev;

    typedef struct {
        logic [2:0] cdiv;
        logic [2:0] udiv;
        int         c_per;
        int         c_high;
        int         u_per;
        int         u_high;
    } vec_t;

    vec_t vecs [6];

    always #5 clock = ~clock;

    clock_divider_unit #(.CNT_W(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .core_div    (core_div),
        .user_div    (user_div),
        .core_clk    (core_clk),
        .user_clk    (user_clk)
`ifdef CLK_EDGE_COUNT_EN
        ,
        .count_start (count_start),
        .count_stop  (count_stop),
        .core_count  (core_count),
        .user_count  (user_count),
        .count_busy  (count_busy)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end else begin
            $display("[TB] ok   %s: %0d", name, act);
        end
    endtask

    // Sample both outputs 1ns after each edge; even index = after posedge
    task automatic sample_half(input int n, output logic [63:0] c, output logic [63:0] u);
        c = '0;
        u = '0;
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) @(posedge clock);
            else            @(negedge clock);
            #1;
            c[i] = core_clk;
            u[i] = user_clk;
        end
    endtask

    // Period and high time, in half-cycles, between the first two rises
    function automatic void measure(input logic [63:0] s, input int n, output int period, output int high);
        int r1 = -1;
        int r2 = -1;
        period = 0;
        high   = 0;
        for (int i = 1; i < n; i++) begin
            if (s[i] && !s[i-1]) begin
                if (r1 < 0)      r1 = i;
                else if (r2 < 0) r2 = i;
            end
        end
        if (r2 > 0) begin
            period = r2 - r1;
            for (int i = r1; i < r2; i++) if (s[i]) high++;
        end
    endfunction

`ifdef CLK_EDGE_COUNT_EN
    task automatic run_window(input logic [2:0] cd, input logic [2:0] ud, input int w,
                              input bit both, input int exp_c, input int exp_u, input string tag);
        core_div = cd;
        user_div = ud;
        repeat (20) @(posedge clock);
        #1;
        count_start = 1'b1;
        count_stop  = both;
        @(posedge clock);
        #1;
        count_start = 1'b0;
        count_stop  = 1'b0;
        check({tag, "_busy_on"}, count_busy, 1);
        check({tag, "_core_clr"}, core_count, 0);
        check({tag, "_user_clr"}, user_count, 0);
        repeat (w - 1) @(posedge clock);
        #1;
        count_stop = 1'b1;
        @(posedge clock);
        #1;
        count_stop = 1'b0;
        check({tag, "_busy_off"}, count_busy, 0);
        check({tag, "_core_count"}, core_count, exp_c);
        check({tag, "_user_count"}, user_count, exp_u);
        repeat (5) @(posedge clock);
        #1;
        check({tag, "_core_frozen"}, core_count, exp_c);
    endtask
`endif

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        // Expected period/high in half-cycles: 2N/N, bypass 2/1
        vecs[0] = '{3'd1, 3'd1,  2, 1,  2, 1};
        vecs[1] = '{3'd3, 3'd1,  6, 3,  2, 1};
        vecs[2] = '{3'd4, 3'd1,  8, 4,  2, 1};
        vecs[3] = '{3'd2, 3'd5,  4, 2, 10, 5};
        vecs[4] = '{3'd7, 3'd6, 14, 7, 12, 6};
        vecs[5] = '{3'd0, 3'd3,  2, 1,  6, 3};

        // Outputs low under reset even with clock high
        repeat (3) @(posedge clock);
        #1;
        check("rst_core_clk", core_clk, 0);
        check("rst_user_clk", user_clk, 0);
        @(posedge clock);
        #2 reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            core_div = vecs[v].cdiv;
            user_div = vecs[v].udiv;
            repeat (20) @(posedge clock);
            sample_half(40, cs, us);
            measure(cs, 40, p, h);
            check($sformatf("v%0d_core_period", v), p, vecs[v].c_per);
            check($sformatf("v%0d_core_high", v), h, vecs[v].c_high);
            measure(us, 40, p, h);
            check($sformatf("v%0d_user_period", v), p, vecs[v].u_per);
            check($sformatf("v%0d_user_high", v), h, vecs[v].u_high);
        end

        // Asynchronous reset in the high phase of a divide-by-5 period
        core_div = 3'd5;
        user_div = 3'd1;
        repeat (20) @(posedge clock);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clock);
            #1;
            if (core_clk) found = 1'b1;
        end
        check("sync_core_high", found, 1);
        #1 reset = 1'b1;
        #1;
        check("async_rst_core", core_clk, 0);
        check("async_rst_user", user_clk, 0);
        repeat (2) @(posedge clock);
        #1;
        check("rst_hold_core", core_clk, 0);
        #1 reset = 1'b0;
        sample_half(12, cs, us);
        check("rst_core_pattern", int'(cs[11:0]), 'hC1F);
        check("rst_user_pattern", int'(us[11:0]), 'h555);

        // Divisor 4 -> 6 during the second high cycle of a period
        core_div = 3'd4;
        repeat (20) @(posedge clock);
        prev  = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clock);
            #1;
            if (core_clk && !prev) found = 1'b1;
            prev = core_clk;
        end
        check("sync_core_rise", found, 1);
        cs    = '0;
        cs[0] = core_clk;
        for (int i = 1; i < 21; i++) begin
            if (i % 2 == 0) @(posedge clock);
            else            @(negedge clock);
            #1;
            cs[i] = core_clk;
            if (i == 2) core_div = 3'd6;
        end
        check("div_4_to_6_pattern", int'(cs[20:0]), 'h103F0F);

`ifdef CLK_EDGE_COUNT_EN
        run_window(3'd1, 3'd1, 1078, 1'b0, 1078, 1078, "win_1_1");
        run_window(3'd3, 3'd1, 3249, 1'b0, 1083, 3249, "win_3_1");
        run_window(3'd4, 3'd1, 4292, 1'b0, 1073, 4292, "win_4_1");
        run_window(3'd3, 3'd1, 33, 1'b1, 11, 33, "win_both");
        // Stop while idle leaves everything unchanged
        #1 count_stop = 1'b1;
        @(posedge clock);
        #1 count_stop = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("idle_stop_busy", count_busy, 0);
        check("idle_stop_core", core_count, 11);
        check("idle_stop_user", user_count, 33);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
